pkmc_sdram_refexec: RTL and testbench



---
 rtl/pkmc_sdram_refexec.sv | 150 +++++++++++++++
 tb/tb_pkmc_sdram_refexec.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pkmc_sdram_refexec.sv
// SDRAM refresh executor: waits for an idle bus, then PRECHARGE ALL, AUTO REFRESH, ack.
// Define PKMC_REF_BURST_EN to issue NUM_REF AUTO REFRESH commands per request (default: one).
module pkmc_sdram_refexec #(
  parameter int T_RP    = 2,
  parameter int T_RFC   = 7,
  parameter int NUM_REF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_req,
  input  logic bus_idle,
  output logic ref_busy,
  output logic ref_ack,
  output logic cs_n,
  output logic ras_n,
  output logic cas_n,
  output logic we_n,
  output logic a10
);

  localparam int MAXW = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {IDLE, PRE, TRP, REF, TRFC, ACK, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          hold_cnt;
  logic [6:0]    outs;
  logic          more_ref;
  logic          more_trfc;

  // Output image per state: {cs_n, ras_n, cas_n, we_n, a10, ref_busy, ref_ack}
  function automatic logic [6:0] enc(state_t s);
    case (s)
      PRE:       enc = 7'b0010110;
      TRP, TRFC: enc = 7'b0111010;
      REF:       enc = 7'b0001010;
      ACK:       enc = 7'b1111001;
      default:   enc = 7'b1111000;
    endcase
  endfunction

`ifdef PKMC_REF_BURST_EN
  logic [3:0] rem;
  // more_ref is evaluated in REF, before that cycle's decrement lands
  assign more_ref  = (rem != 4'd1);
  assign more_trfc = (rem != 4'd0);
`else
  assign more_ref  = 1'b0;
  assign more_trfc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      outs     <= enc(IDLE);
      wait_cnt <= '0;
      hold_cnt <= 1'b0;
`ifdef PKMC_REF_BURST_EN
      rem      <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ref_req && bus_idle) begin
            state    <= PRE;
            outs     <= enc(PRE);
            wait_cnt <= CW'(T_RP - 1);
`ifdef PKMC_REF_BURST_EN
            rem      <= 4'(NUM_REF);
`endif
          end
        end
        PRE: begin
          if (T_RP == 1) begin
            state    <= REF;
            outs     <= enc(REF);
            wait_cnt <= CW'(T_RFC - 1);
          end else begin
            state <= TRP;
            outs  <= enc(TRP);
          end
        end
        TRP: begin
          if (wait_cnt == CW'(1)) begin
            state    <= REF;
            outs     <= enc(REF);
            wait_cnt <= CW'(T_RFC - 1);
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        REF: begin
`ifdef PKMC_REF_BURST_EN
          rem <= rem - 4'd1;
`endif
          if (T_RFC == 1) begin
            if (more_ref) begin
              state    <= REF;
              outs     <= enc(REF);
              wait_cnt <= CW'(T_RFC - 1);
            end else begin
              state <= ACK;
              outs  <= enc(ACK);
            end
          end else begin
            state <= TRFC;
            outs  <= enc(TRFC);
          end
        end
        TRFC: begin
          if (wait_cnt == CW'(1)) begin
            if (more_trfc) begin
              state    <= REF;
              outs     <= enc(REF);
              wait_cnt <= CW'(T_RFC - 1);
            end else begin
              state <= ACK;
              outs  <= enc(ACK);
            end
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ACK: begin
          state    <= HOLD;
          outs     <= enc(HOLD);
          hold_cnt <= 1'b1;
        end
        HOLD: begin
          // Two dead cycles let the counter's clear settle before ref_req is trusted again
          if (hold_cnt == 1'b0) begin
            state <= IDLE;
            outs  <= enc(IDLE);
          end else begin
            hold_cnt <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          outs  <= enc(IDLE);
        end
      endcase
    end
  end

  assign {cs_n, ras_n, cas_n, we_n, a10, ref_busy, ref_ack} = outs;

endmodule

// File: tb/tb_pkmc_sdram_refexec.sv
// Directed bench for pkmc_sdram_refexec: default timing DUT plus a T_RP=1/T_RFC=1 DUT.
module tb_pkmc_sdram_refexec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_req = 1'b0;
  logic bus_idle = 1'b0;

  logic busy1, ack1, cs1, ras1, cas1, we1, a101;
  logic busy2, ack2, cs2, ras2, cas2, we2, a102;

  int tests = 0;
  int fails = 0;

  // {cs_n, ras_n, cas_n, we_n, a10, ref_busy, ref_ack}
  localparam logic [6:0] DESEL = 7'b1111000;
  localparam logic [6:0] ACKV  = 7'b1111001;
  localparam logic [6:0] PREV  = 7'b0010110;
  localparam logic [6:0] NOPV  = 7'b0111010;
  localparam logic [6:0] REFV  = 7'b0001010;

  pkmc_sdram_refexec dut1 (
    .clk(clk), .rst(rst), .ref_req(ref_req), .bus_idle(bus_idle),
    .ref_busy(busy1), .ref_ack(ack1), .cs_n(cs1), .ras_n(ras1),
    .cas_n(cas1), .we_n(we1), .a10(a101)
  );

  pkmc_sdram_refexec #(.T_RP(1), .T_RFC(1), .NUM_REF(2)) dut2 (
    .clk(clk), .rst(rst), .ref_req(ref_req), .bus_idle(bus_idle),
    .ref_busy(busy2), .ref_ack(ack2), .cs_n(cs2), .ras_n(ras2),
    .cas_n(cas2), .we_n(we2), .a10(a102)
  );

  always #5 clk = ~clk;

  wire [6:0] o1 = {cs1, ras1, cas1, we1, a101, busy1, ack1};
  wire [6:0] o2 = {cs2, ras2, cas2, we2, a102, busy2, ack2};

  task automatic chk(input string tag, input int c, input logic [6:0] got, input logic [6:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s c%0d observed=%b expected=%b", tag, c, got, exp);
    end
  endtask

  // Request held high throughout; sequence restarts right after the hold window
  function automatic logic [6:0] exp_main(int c);
`ifdef PKMC_REF_BURST_EN
    if (c == 1 || c == 21) return PREV;
    if (c == 3 || c == 10) return REFV;
    if (c == 17) return ACKV;
    if (c >= 18 && c <= 20) return DESEL;
    return NOPV;
`else
    if (c == 1 || c == 14) return PREV;
    if (c == 3) return REFV;
    if (c == 10) return ACKV;
    if (c >= 11 && c <= 13) return DESEL;
    return NOPV;
`endif
  endfunction

  function automatic logic [6:0] exp_fast(int c);
    int k;
`ifdef PKMC_REF_BURST_EN
    k = (c - 1) % 7;
    if (k == 0) return PREV;
    if (k == 1 || k == 2) return REFV;
    if (k == 3) return ACKV;
    return DESEL;
`else
    k = (c - 1) % 6;
    if (k == 0) return PREV;
    if (k == 1) return REFV;
    if (k == 2) return ACKV;
    return DESEL;
`endif
  endfunction

  initial begin
`ifdef PKMC_REF_BURST_EN
    int last = 21;
`else
    int last = 14;
`endif
    // Reset held three cycles
    repeat (3) @(negedge clk);
    chk("reset_dut1", 0, o1, DESEL);
    chk("reset_dut2", 0, o2, DESEL);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 0, o1, DESEL);

    // Main sequence: request sampled in cycle 0, held high through the ack
    ref_req  = 1'b1;
    bus_idle = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      chk("main_seq", c, o1, exp_main(c));
      chk("fast_seq", c, o2, exp_fast(c));
    end

    ref_req = 1'b0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_again", 0, o1, DESEL);

    // Request pending while the access FSM is busy
    ref_req  = 1'b1;
    bus_idle = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("bus_busy_hold", c, o1, DESEL);
    end
    bus_idle = 1'b1;
    @(negedge clk);
    chk("pre_after_idle", 1, o1, PREV);
    bus_idle = 1'b0;
    @(negedge clk);
    chk("late_idle_drop", 2, o1, NOPV);
    @(negedge clk);
    chk("ref_after_trp", 3, o1, REFV);
    @(negedge clk);
    chk("trfc_c4", 4, o1, NOPV);
    @(negedge clk);
    chk("trfc_c5", 5, o1, NOPV);

    // Abort mid-tRFC
    rst = 1'b1;
    @(negedge clk);
    chk("abort_desel", 6, o1, DESEL);
    rst     = 1'b0;
    ref_req = 1'b0;
    for (int c = 7; c <= 18; c++) begin
      @(negedge clk);
      chk("abort_no_ack", c, o1, DESEL);
    end

    ref_req  = 1'b1;
    bus_idle = 1'b1;
    @(negedge clk);
    chk("restart_pre", 1, o1, PREV);
    ref_req = 1'b0;
    @(negedge clk);
    chk("restart_nop", 2, o1, NOPV);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
